chime_alarm_gen: RTL and testbench
==================================

// Module: chime_alarm_gen
// PURPOSE
//  Parametrised hourly-chime and alarm tone generator for the digital clock.
//  Counts whole seconds from the timekeeper's cur_sec/sec_tick through an FSM:
//  PRE_BEEPS short low-tone beeps, then one high-tone beep at the period boundary.
//  Adds a programmable daily alarm with acknowledge; alarm preempts the chime.
//  Drives the single-bit speaker pin directly.
// PARAMETERS
//  SEC_W       17     width of cur_sec / alarm_sec (seconds of day, 0..86399)
//  PERIOD      3600   chime period in seconds (chime ends at cur_sec%PERIOD==0)
//  PRE_BEEPS   4      low beeps before boundary, 1..PERIOD/2-1
//  DIV_W       16     width of free-running tone divider
//  LO_BIT      15     divider bit used as low tone (< DIV_W)
//  HI_BIT      14     divider bit used as high tone (< DIV_W)
//  ALARM_SECS  60     alarm ring duration in seconds
//  SNOOZE_SECS 300    snooze length (SNOOZE_EN only)
// PORTS
//  clk        in  1      system clock
//  rst_n      in  1      synchronous reset, active low
//  en         in  1      block enable; low forces IDLE, speaker 0
//  cur_sec    in  SEC_W  current time in seconds of day
//  sec_tick   in  1      1-cycle pulse, cur_sec valid with new value this cycle
//  alarm_en   in  1      arms the alarm
//  alarm_sec  in  SEC_W  alarm time in seconds of day
//  alarm_ack  in  1      1-cycle pulse: stop (or snooze) ringing alarm
//  speaker    out 1      tone output, registered
//  ringing    out 1      high while in ALARM, registered
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge clk): state=IDLE, divider=0, sec counters=0,
//    speaker=0, ringing=0. Takes priority over everything incl. en.
//  - Divider increments every clk when not in reset, regardless of en/state.
//  - States: IDLE, PRE (low-beep window), TOP (high beep), ALARM, SNOOZE*.
//  - All transitions evaluated only on sec_tick cycles except ack and en.
//  - IDLE->PRE: sec_tick && cur_sec%PERIOD == PERIOD-2*PRE_BEEPS; sec_cnt=0.
//  - PRE: speaker=divider[LO_BIT] when sec_cnt even, 0 when odd; sec_cnt++ per
//    tick; after 2*PRE_BEEPS seconds (tick with cur_sec%PERIOD==0) -> TOP.
//  - TOP: speaker=divider[HI_BIT] for one second; next tick -> IDLE.
//  - Any state except ALARM/SNOOZE -> ALARM: sec_tick && alarm_en &&
//    cur_sec==alarm_sec; sec_cnt=0. Alarm preempts an active chime.
//  - ALARM: speaker=divider[HI_BIT] in even seconds, divider[LO_BIT] in odd;
//    ringing=1; after ALARM_SECS ticks -> IDLE; alarm_ack -> IDLE next cycle.
//  - alarm_ack outside ALARM ignored; ack and entering tick same cycle: enter
//    ALARM, ack discarded. alarm_en dropped while ALARM -> IDLE next cycle.
//  - Chime trigger while ALARM/SNOOZE ignored (that hour's chime is lost).
//  - Outputs registered: speaker/ringing reflect new state 1 clk after the
//    deciding sec_tick/ack edge.
//  - en=0: state->IDLE, speaker=0, ringing=0 next cycle; no events latched.
//  - cur_sec >= 86400 never matches alarm; % computed combinationally, SEC_W bits.
//  - Midnight wrap (86399->0) is a normal boundary: TOP fires at cur_sec=0.
// CONFIGURATION
//  SNOOZE_EN defined: alarm_ack in ALARM -> SNOOZE (speaker 0, ringing 0);
//    after SNOOZE_SECS ticks -> ALARM with sec_cnt=0; alarm_en=0 in SNOOZE
//    -> IDLE. Unlimited snoozes.
//  SNOOZE_EN undefined: no SNOOZE state; alarm_ack in ALARM -> IDLE.
// TESTING
//  1 ticks cur_sec 3591..3600, defaults -> low tone in 3592/94/96/98, silent
//    3593/95/97/99, HI_BIT tone at 3600, IDLE at 3601.
//  2 alarm_en=1, alarm_sec=25200, tick at 25200 -> ringing=1 next clk;
//    alternates tones; ringing=0 after 60 ticks.
//  3 alarm ringing, alarm_ack pulse -> ringing=0, speaker=0 next clk;
//    with SNOOZE_EN ringing returns exactly 300 ticks later.
//  4 alarm_sec=3595 during chime -> ALARM preempts at 3595; 3600 no HI beep.
//  5 rst_n=0 / en=0 mid-PRE -> speaker=0 next clk; en=1 at 3597 -> no chime.
//  6 PERIOD=60, PRE_BEEPS=2, ticks 86395..86399,0 -> beeps at 56,58, top at 0.

Source files
------------

// File: rtl/chime_alarm_gen.sv
// chime_alarm_gen: hourly chime plus daily alarm tone generator.
// A seconds-driven FSM plays PRE_BEEPS low beeps ahead of each PERIOD boundary,
// then a single high beep on the boundary second. A programmable alarm preempts
// the chime and rings alternating tones until timeout, acknowledge or disarm.
// Optional feature macro: SNOOZE_EN (acknowledge snoozes instead of stopping).
module chime_alarm_gen #(
    parameter int SEC_W       = 17,
    parameter int PERIOD      = 3600,
    parameter int PRE_BEEPS   = 4,
    parameter int DIV_W       = 16,
    parameter int LO_BIT      = 15,
    parameter int HI_BIT      = 14,
    parameter int ALARM_SECS  = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [SEC_W-1:0] cur_sec,
    input  logic             sec_tick,
    input  logic             alarm_en,
    input  logic [SEC_W-1:0] alarm_sec,
    input  logic             alarm_ack,
    output logic             speaker,
    output logic             ringing
);

    localparam int DAY_SECS    = 86400;
    localparam int CHIME_START = PERIOD - 2 * PRE_BEEPS;
    localparam int CNT_MAX_A   = (ALARM_SECS > 2 * PRE_BEEPS) ? ALARM_SECS : 2 * PRE_BEEPS;
    localparam int CNT_MAX     = (SNOOZE_SECS > CNT_MAX_A) ? SNOOZE_SECS : CNT_MAX_A;
    localparam int CNT_W       = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_TOP,
        S_ALARM
`ifdef SNOOZE_EN
        ,
        S_SNOOZE
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   sec_cnt_q, sec_cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               speaker_q, speaker_d;
    logic               ringing_q, ringing_d;

    logic [SEC_W-1:0]   phase;
    logic               alarm_hit;
    logic               chime_hit;

    // Position of the current second within the chime period, and trigger decodes.
    always_comb begin
        phase     = cur_sec % SEC_W'(PERIOD);
        alarm_hit = sec_tick && alarm_en && (cur_sec == alarm_sec)
                    && (cur_sec < SEC_W'(DAY_SECS));
        chime_hit = sec_tick && (phase == SEC_W'(CHIME_START));
    end

    // Next-state, second counter and tone selection; outputs are derived from
    // the next state so the registered pins track the state register exactly.
    always_comb begin
        state_d   = state_q;
        sec_cnt_d = sec_cnt_q;
        div_d     = div_q + 1'b1;
        speaker_d = 1'b0;
        ringing_d = 1'b0;

        if (!en) begin
            state_d   = S_IDLE;
            sec_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (alarm_hit) begin
                        state_d   = S_ALARM;
                        sec_cnt_d = '0;
                    end else if (chime_hit) begin
                        state_d   = S_PRE;
                        sec_cnt_d = '0;
                    end
                end
                S_PRE: begin
                    if (alarm_hit) begin
                        state_d   = S_ALARM;
                        sec_cnt_d = '0;
                    end else if (sec_tick) begin
                        sec_cnt_d = sec_cnt_q + 1'b1;
                        if (phase == '0) begin
                            state_d = S_TOP;
                        end
                    end
                end
                S_TOP: begin
                    if (alarm_hit) begin
                        state_d   = S_ALARM;
                        sec_cnt_d = '0;
                    end else if (sec_tick) begin
                        state_d = S_IDLE;
                    end
                end
                S_ALARM: begin
                    if (!alarm_en) begin
                        state_d = S_IDLE;
                    end else if (alarm_ack) begin
`ifdef SNOOZE_EN
                        state_d   = S_SNOOZE;
                        sec_cnt_d = '0;
`else
                        state_d = S_IDLE;
`endif
                    end else if (sec_tick) begin
                        if (sec_cnt_q == CNT_W'(ALARM_SECS - 1)) begin
                            state_d = S_IDLE;
                        end else begin
                            sec_cnt_d = sec_cnt_q + 1'b1;
                        end
                    end
                end
`ifdef SNOOZE_EN
                S_SNOOZE: begin
                    if (!alarm_en) begin
                        state_d = S_IDLE;
                    end else if (sec_tick) begin
                        if (sec_cnt_q == CNT_W'(SNOOZE_SECS - 1)) begin
                            state_d   = S_ALARM;
                            sec_cnt_d = '0;
                        end else begin
                            sec_cnt_d = sec_cnt_q + 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        unique case (state_d)
            S_PRE:   speaker_d = sec_cnt_d[0] ? 1'b0 : div_d[LO_BIT];
            S_TOP:   speaker_d = div_d[HI_BIT];
            S_ALARM: begin
                speaker_d = sec_cnt_d[0] ? div_d[LO_BIT] : div_d[HI_BIT];
                ringing_d = 1'b1;
            end
            default: begin
                speaker_d = 1'b0;
                ringing_d = 1'b0;
            end
        endcase
    end

    // State, counters, divider and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sec_cnt_q <= '0;
            div_q     <= '0;
            speaker_q <= 1'b0;
            ringing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sec_cnt_q <= sec_cnt_d;
            div_q     <= div_d;
            speaker_q <= speaker_d;
            ringing_q <= ringing_d;
        end
    end

    assign speaker = speaker_q;
    assign ringing = ringing_q;

endmodule

// File: tb/tb_chime_alarm_gen.sv
// Self-checking bench for chime_alarm_gen: two instances (hourly period and a
// 60 s period) share one stimulus stream; a behavioural timeline model predicts
// speaker/ringing every cycle, with literal expectations at key seconds.
module tb_chime_alarm_gen;

    localparam int GAP     = 8;   // clocks per simulated second
    localparam int DIVW    = 4;
    localparam int LOB     = 3;
    localparam int HIB     = 1;
    localparam int A_SECS  = 60;
    localparam int Z_SECS  = 300;

    localparam int M_IDLE   = 0;
    localparam int M_PRE    = 1;
    localparam int M_TOP    = 2;
    localparam int M_ALARM  = 3;
    localparam int M_SNOOZE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic [16:0] cur_sec = '0;
    logic        sec_tick = 1'b0;
    logic        alarm_en = 1'b0;
    logic [16:0] alarm_sec = '0;
    logic        alarm_ack = 1'b0;
    logic        spk0, ring0, spk1, ring1;

    always #5 clk = ~clk;

    chime_alarm_gen #(
        .SEC_W(17), .PERIOD(3600), .PRE_BEEPS(4), .DIV_W(DIVW), .LO_BIT(LOB),
        .HI_BIT(HIB), .ALARM_SECS(A_SECS), .SNOOZE_SECS(Z_SECS)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .cur_sec(cur_sec), .sec_tick(sec_tick),
        .alarm_en(alarm_en), .alarm_sec(alarm_sec), .alarm_ack(alarm_ack),
        .speaker(spk0), .ringing(ring0)
    );

    chime_alarm_gen #(
        .SEC_W(17), .PERIOD(60), .PRE_BEEPS(2), .DIV_W(DIVW), .LO_BIT(LOB),
        .HI_BIT(HIB), .ALARM_SECS(A_SECS), .SNOOZE_SECS(Z_SECS)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .cur_sec(cur_sec), .sec_tick(sec_tick),
        .alarm_en(alarm_en), .alarm_sec(alarm_sec), .alarm_ack(alarm_ack),
        .speaker(spk1), .ringing(ring1)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_on  = 1'b0;
    bit done    = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int m_mode[2] = '{M_IDLE, M_IDLE};
    int m_cnt[2]  = '{0, 0};
    int m_div     = 0;
    int per[2]    = '{3600, 60};
    int pbs[2]    = '{4, 2};

    function automatic bit snooze_on();
`ifdef SNOOZE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step(input int i);
        int s;
        bit tick, hit;
        s    = int'(cur_sec);
        tick = sec_tick;
        hit  = tick && alarm_en && (cur_sec == alarm_sec) && (s < 86400);
        if (!en) begin
            m_mode[i] = M_IDLE;
        end else if (m_mode[i] == M_ALARM) begin
            if (!alarm_en) m_mode[i] = M_IDLE;
            else if (alarm_ack) begin
                if (snooze_on()) begin m_mode[i] = M_SNOOZE; m_cnt[i] = 0; end
                else m_mode[i] = M_IDLE;
            end else if (tick) begin
                m_cnt[i]++;
                if (m_cnt[i] == A_SECS) m_mode[i] = M_IDLE;
            end
        end else if (m_mode[i] == M_SNOOZE) begin
            if (!alarm_en) m_mode[i] = M_IDLE;
            else if (tick) begin
                m_cnt[i]++;
                if (m_cnt[i] == Z_SECS) begin m_mode[i] = M_ALARM; m_cnt[i] = 0; end
            end
        end else if (tick) begin
            if (hit) begin
                m_mode[i] = M_ALARM; m_cnt[i] = 0;
            end else if (m_mode[i] == M_PRE) begin
                m_cnt[i]++;
                if (m_cnt[i] == 2 * pbs[i]) m_mode[i] = M_TOP;
            end else if (m_mode[i] == M_TOP) begin
                m_mode[i] = M_IDLE;
            end else if (s % per[i] == per[i] - 2 * pbs[i]) begin
                m_mode[i] = M_PRE; m_cnt[i] = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_div  = 0;
            m_mode = '{M_IDLE, M_IDLE};
            m_cnt  = '{0, 0};
        end else begin
            m_div = (m_div + 1) % (1 << DIVW);
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    function automatic int exp_spk(input int i);
        int lo, hi;
        lo = (m_div >> LOB) & 1;
        hi = (m_div >> HIB) & 1;
        case (m_mode[i])
            M_PRE:   return (m_cnt[i] % 2 == 0) ? lo : 0;
            M_TOP:   return hi;
            M_ALARM: return (m_cnt[i] % 2 == 0) ? hi : lo;
            default: return 0;
        endcase
    endfunction

    // Per-cycle comparison of both instances against the model.
    initial begin
        wait (chk_on);
        while (!done) begin
            @(posedge clk);
            #1;
            if (!done) begin
                check("spk_p3600", int'(spk0), exp_spk(0));
                check("ring_p3600", int'(ring0), int'(m_mode[0] == M_ALARM));
                check("spk_p60", int'(spk1), exp_spk(1));
                check("ring_p60", int'(ring1), int'(m_mode[1] == M_ALARM));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick_sec(input int s);
        @(negedge clk);
        cur_sec  = s[16:0];
        sec_tick = 1'b1;
        @(negedge clk);
        sec_tick = 1'b0;
        repeat (GAP - 2) @(negedge clk);
    endtask

    task automatic tick_range(input int a, input int b);
        for (int s = a; s <= b; s++) tick_sec(s);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        alarm_ack = 1'b1;
        @(negedge clk);
        alarm_ack = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        chk_on = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_speaker", int'(spk0), 0);
        check("reset_ringing", int'(ring0), 0);
        rst_n = 1'b1;

        // 1: hourly chime 3591..3601
        tick_range(3591, 3592);
        check("t1_model_pre", m_mode[0], M_PRE);
        tick_sec(3593);
        check("t1_silent_3593", int'(spk0), 0);
        tick_range(3594, 3599);
        check("t1_silent_3599", int'(spk0), 0);
        tick_sec(3600);
        check("t1_model_top", m_mode[0], M_TOP);
        tick_sec(3601);
        check("t1_idle_3601", int'(spk0), 0);
        check("t1_model_idle", m_mode[0], M_IDLE);

        // 2: alarm at 25200 rings 60 ticks; stray ack in IDLE ignored
        alarm_en  = 1'b1;
        alarm_sec = 17'd25200;
        pulse_ack();
        tick_sec(25199);
        check("t2_pre_ring", int'(ring0), 0);
        tick_sec(25200);
        check("t2_ring_on", int'(ring0), 1);
        tick_range(25201, 25259);
        check("t2_ring_59", int'(ring0), 1);
        tick_sec(25260);
        check("t2_ring_off", int'(ring0), 0);

        // 3: ack in same cycle as entering tick is discarded; later ack stops/snoozes
        alarm_sec = 17'd30000;
        @(negedge clk);
        cur_sec = 17'd30000; sec_tick = 1'b1; alarm_ack = 1'b1;
        @(negedge clk);
        sec_tick = 1'b0; alarm_ack = 1'b0;
        repeat (GAP - 2) @(negedge clk);
        check("t3_ack_at_entry", int'(ring0), 1);
        tick_sec(30001);
        pulse_ack();
        check("t3_ack_ring", int'(ring0), 0);
        check("t3_ack_spk", int'(spk0), 0);
`ifdef SNOOZE_EN
        tick_range(30002, 30300);
        check("t3_snooze_299", int'(ring0), 0);
        tick_sec(30301);
        check("t3_snooze_300", int'(ring0), 1);
        check("t3_model_alarm", m_mode[0], M_ALARM);
`else
        tick_range(30002, 30005);
        check("t3_stays_off", int'(ring0), 0);
`endif
        @(negedge clk);
        alarm_en = 1'b0;
        @(negedge clk);
        check("t3_disarm", int'(ring0), 0);

        // 4: alarm preempts chime at 3595; no high beep at 3600
        alarm_en  = 1'b1;
        alarm_sec = 17'd3595;
        tick_range(3590, 3594);
        check("t4_pre", m_mode[0], M_PRE);
        tick_sec(3595);
        check("t4_preempt", int'(ring0), 1);
        tick_range(3596, 3600);
        check("t4_still_alarm", int'(ring0), 1);
        check("t4_model_alarm", m_mode[0], M_ALARM);
        @(negedge clk);
        alarm_en = 1'b0;
        @(negedge clk);
        check("t4_disarm", int'(ring0), 0);

        // 5: reset and enable drop mid-PRE
        tick_range(3590, 3594);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_rst_spk", int'(spk0), 0);
        check("t5_rst_model", m_mode[0], M_IDLE);
        tick_range(3590, 3594);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("t5_en_spk", int'(spk0), 0);
        tick_range(3595, 3596);
        en = 1'b1;
        for (int s = 3597; s <= 3601; s++) begin
            tick_sec(s);
            check("t5_no_chime", int'(spk0), 0);
        end

        // 6: midnight wrap, 60 s period chime
        tick_range(86390, 86396);
        check("t6_p60_pre", m_mode[1], M_PRE);
        tick_range(86397, 86399);
        tick_sec(0);
        check("t6_p60_top", m_mode[1], M_TOP);
        check("t6_p3600_top", m_mode[0], M_TOP);
        tick_sec(1);
        check("t6_p60_idle", m_mode[1], M_IDLE);
        check("t6_idle_spk", int'(spk1), 0);

        // out-of-day alarm time never matches
        alarm_en  = 1'b1;
        alarm_sec = 17'd86400;
        tick_sec(86400);
        check("t6_alarm_86400", int'(ring0), 0);
        alarm_en = 1'b0;
        tick_sec(2);

        done = 1'b1;
        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard bound on run time.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
